// File: rtl/breathing_duty_sequencer_pkg.sv
// Shared types and widths for the breathing duty sequencer.
package breathing_pkg;

    // Ramp phase, also exported on the Phase output
    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } phase_e;

    localparam int DUTY_W       = 8;
    localparam int COUNT_W      = 24;
    localparam int DUTY_ABS_MAX = 100;

endpackage

// File: rtl/breathing_duty_sequencer_if.sv
// Bus between the breathing sequencer and its controller / PWM stage.
// master: the sequencer (drives duty, period, tick, phase).
// slave : the controller / consumer (drives Enable).
interface breathing_duty_sequencer_if;
    import breathing_pkg::*;

    logic               Enable;
    logic [DUTY_W-1:0]  Duty;
    logic [COUNT_W-1:0] Count_P;
    logic               Period_Tick;
    logic [1:0]         Phase;

    modport master (
        input  Enable,
        output Duty,
        output Count_P,
        output Period_Tick,
        output Phase
    );

    modport slave (
        output Enable,
        input  Duty,
        input  Count_P,
        input  Period_Tick,
        input  Phase
    );

endinterface

// File: rtl/breathing_duty_sequencer_period_tick_gen.sv
// PWM period counter (0..PERIOD_CYCLES-1) and end-of-period strobe.
module period_tick_gen
    import breathing_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 50000
) (
    input  logic CLK,
    input  logic Rst,
    input  logic Enable,
    output logic Period_Tick
);

    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               last_q, last_d;

    // Next counter value; last_q registers "counter is at PERIOD_CYCLES-1"
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (Enable) begin
            if (last_q) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            last_d = (cnt_d == COUNT_W'(PERIOD_CYCLES - 1));
        end
    end

    // Counter state; frozen while Enable is low
    always_ff @(posedge CLK) begin
        if (Rst) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    // The registered last-count flag is qualified by Enable so a pause that
    // lands on the final count neither emits nor loses the period tick.
    assign Period_Tick = last_q & Enable;

endmodule

// File: rtl/breathing_duty_sequencer.sv
// Breathing duty sequencer: ramps Duty between 0 and DUTY_MAX on PWM
// period boundaries. Define BREATH_HOLD_EN to dwell HOLD_PERIODS periods
// at each extreme (HOLD_HI / HOLD_LO); otherwise the ramp reverses at once.
module breathing_duty_sequencer
    import breathing_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 50000,
    parameter int unsigned STEP_PERIODS  = 10,
    parameter int unsigned DUTY_STEP     = 1,
    parameter int unsigned DUTY_MAX      = 100,
    parameter int unsigned HOLD_PERIODS  = 50
) (
    input  logic                         CLK,
    input  logic                         Rst,
    breathing_duty_sequencer_if.master   bus
);

    if (DUTY_MAX > DUTY_ABS_MAX) begin : g_bad_duty_max
        $error("DUTY_MAX must not exceed 100");
    end
    if (HOLD_PERIODS < 1 || STEP_PERIODS < 1) begin : g_bad_periods
        $error("STEP_PERIODS and HOLD_PERIODS must be at least 1");
    end

    localparam logic [1:0] ST_RISE = RISE;
    localparam logic [1:0] ST_FALL = FALL;
`ifdef BREATH_HOLD_EN
    localparam logic [1:0] ST_HOLD_HI = HOLD_HI;
    localparam logic [1:0] ST_HOLD_LO = HOLD_LO;
    localparam int unsigned HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
`endif
    localparam int unsigned STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [DUTY_W-1:0] DMAX_V  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DSTEP_V = DUTY_W'(DUTY_STEP);

    logic              period_tick;
    logic [1:0]        state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              step_hit;
    logic [DUTY_W:0]   rise_sum;
    logic [DUTY_W-1:0] rise_val, fall_val;
`ifdef BREATH_HOLD_EN
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_hit;
`endif

    period_tick_gen #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_period (
        .CLK        (CLK),
        .Rst        (Rst),
        .Enable     (bus.Enable),
        .Period_Tick(period_tick)
    );

    assign step_hit = (step_cnt_q == STEP_W'(STEP_PERIODS - 1));
`ifdef BREATH_HOLD_EN
    assign hold_hit = (hold_cnt_q == HOLD_W'(HOLD_PERIODS - 1));
`endif

    // Ramp FSM: advance step/hold counts on each period tick, saturate duty
    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        step_cnt_d = step_cnt_q;
`ifdef BREATH_HOLD_EN
        hold_cnt_d = hold_cnt_q;
`endif
        rise_sum = {1'b0, duty_q} + (DUTY_W + 1)'(DUTY_STEP);
        rise_val = (rise_sum >= {1'b0, DMAX_V}) ? DMAX_V : rise_sum[DUTY_W-1:0];
        fall_val = (duty_q > DSTEP_V) ? (duty_q - DSTEP_V) : '0;

        if (period_tick) begin
            case (state_q)
                ST_RISE: begin
                    if (step_hit) begin
                        step_cnt_d = '0;
                        duty_d     = rise_val;
                        if (rise_val == DMAX_V) begin
`ifdef BREATH_HOLD_EN
                            state_d = ST_HOLD_HI;
`else
                            state_d = ST_FALL;
`endif
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                ST_FALL: begin
                    if (step_hit) begin
                        step_cnt_d = '0;
                        duty_d     = fall_val;
                        if (fall_val == '0) begin
`ifdef BREATH_HOLD_EN
                            state_d = ST_HOLD_LO;
`else
                            state_d = ST_RISE;
`endif
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
`ifdef BREATH_HOLD_EN
                ST_HOLD_HI: begin
                    if (hold_hit) begin
                        hold_cnt_d = '0;
                        step_cnt_d = '0;
                        state_d    = ST_FALL;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_HOLD_LO: begin
                    if (hold_hit) begin
                        hold_cnt_d = '0;
                        step_cnt_d = '0;
                        state_d    = ST_RISE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_d    = ST_RISE;
                    step_cnt_d = '0;
                end
            endcase
        end
    end

    // FSM, duty and counter registers
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q    <= ST_RISE;
            duty_q     <= '0;
            step_cnt_q <= '0;
`ifdef BREATH_HOLD_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            step_cnt_q <= step_cnt_d;
`ifdef BREATH_HOLD_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign bus.Duty        = duty_q;
    assign bus.Phase       = state_q;
    assign bus.Period_Tick = period_tick;
    assign bus.Count_P     = COUNT_W'(PERIOD_CYCLES);

endmodule

// File: tb/tb_breathing_duty_sequencer.sv
// Testbench for breathing_duty_sequencer: two instances (DUTY_STEP 25 and 30)
// compared each cycle against a tick-counting reference model.
module tb_breathing_duty_sequencer;

    localparam int P    = 4;
    localparam int SP   = 2;
    localparam int DMAX = 100;
    localparam int HOLD = 3;
`ifdef BREATH_HOLD_EN
    localparam bit HOLD_BUILD = 1'b1;
`else
    localparam bit HOLD_BUILD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic Rst = 1'b1;
    logic en  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = DUTY_STEP 25, index 1 = DUTY_STEP 30
    int ds[2] = '{25, 30};
    int m_e[2];      // enabled cycles since reset
    int m_duty[2];
    int m_phase[2];
    int m_n[2];      // ticks spent in the current phase

    breathing_duty_sequencer_if bus_a ();
    breathing_duty_sequencer_if bus_b ();

    breathing_duty_sequencer #(
        .PERIOD_CYCLES(P), .STEP_PERIODS(SP), .DUTY_STEP(25),
        .DUTY_MAX(DMAX), .HOLD_PERIODS(HOLD)
    ) dut_a (
        .CLK(CLK), .Rst(Rst), .bus(bus_a)
    );

    breathing_duty_sequencer #(
        .PERIOD_CYCLES(P), .STEP_PERIODS(SP), .DUTY_STEP(30),
        .DUTY_MAX(DMAX), .HOLD_PERIODS(HOLD)
    ) dut_b (
        .CLK(CLK), .Rst(Rst), .bus(bus_b)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one rising edge to the model of instance i
    function automatic void model_edge(int i, bit r, bit e);
        bit t;
        if (r) begin
            m_e[i] = 0; m_duty[i] = 0; m_phase[i] = 0; m_n[i] = 0;
        end else if (e) begin
            t = (m_e[i] % P) == P - 1;
            m_e[i]++;
            if (t) begin
                m_n[i]++;
                if (m_phase[i] == 0) begin
                    if (m_n[i] % SP == 0) begin
                        m_duty[i] = (m_duty[i] + ds[i] > DMAX) ? DMAX : m_duty[i] + ds[i];
                        if (m_duty[i] == DMAX) begin
                            m_phase[i] = HOLD_BUILD ? 1 : 2;
                            m_n[i] = 0;
                        end
                    end
                end else if (m_phase[i] == 2) begin
                    if (m_n[i] % SP == 0) begin
                        m_duty[i] = (m_duty[i] < ds[i]) ? 0 : m_duty[i] - ds[i];
                        if (m_duty[i] == 0) begin
                            m_phase[i] = HOLD_BUILD ? 3 : 0;
                            m_n[i] = 0;
                        end
                    end
                end else if (m_n[i] == HOLD) begin
                    m_phase[i] = (m_phase[i] + 1) % 4;
                    m_n[i] = 0;
                end
            end
        end
    endfunction

    task automatic drive(input bit r, input bit e);
        Rst = r;
        en  = e;
        bus_a.Enable = e;
        bus_b.Enable = e;
    endtask

    // One clock: update the model at the edge, compare on the falling edge
    task automatic step_cycle();
        @(posedge CLK);
        model_edge(0, Rst, en);
        model_edge(1, Rst, en);
        @(negedge CLK);
        chk("duty_a",  bus_a.Duty,        m_duty[0]);
        chk("phase_a", bus_a.Phase,       m_phase[0]);
        chk("tick_a",  bus_a.Period_Tick, (en && (m_e[0] % P) == P - 1) ? 1 : 0);
        chk("duty_b",  bus_b.Duty,        m_duty[1]);
        chk("phase_b", bus_b.Phase,       m_phase[1]);
        chk("tick_b",  bus_b.Period_Tick, (en && (m_e[1] % P) == P - 1) ? 1 : 0);
    endtask

    initial begin
        bit found;

        // Reset
        drive(1'b1, 1'b0);
        repeat (2) step_cycle();
        chk("rst_duty",   bus_a.Duty,        0);
        chk("rst_phase",  bus_a.Phase,       0);
        chk("rst_tick",   bus_a.Period_Tick, 0);
        chk("rst_countp", bus_a.Count_P,     P);

        // Directed ramp-up timing (cycle c = c-th enabled edge)
        drive(1'b0, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            step_cycle();
            if (c == 3)  chk("ramp_tick3",   bus_a.Period_Tick, 1);
            if (c == 7)  chk("ramp_duty7",   bus_a.Duty, 0);
            if (c == 8)  chk("ramp_duty8",   bus_a.Duty, 25);
            if (c == 16) chk("ramp_duty16",  bus_a.Duty, 50);
            if (c == 24) chk("sat_duty24_b", bus_b.Duty, 90);
            if (c == 32) chk("ramp_duty32",  bus_a.Duty, 100);
            if (c == 32) chk("sat_duty32_b", bus_b.Duty, 100);
            if (c == 32) chk("ramp_phase32", bus_a.Phase, HOLD_BUILD ? 1 : 2);
        end
        repeat (160) step_cycle();

        // Reset pulse mid-FALL
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (bus_a.Phase == 2 && bus_a.Duty != 0 && bus_a.Duty != 100) found = 1'b1;
            else step_cycle();
        end
        chk("reach_fall", found, 1);
        drive(1'b1, 1'b1);
        step_cycle();
        chk("rst_fall_duty",  bus_a.Duty,  0);
        chk("rst_fall_phase", bus_a.Phase, 0);
        drive(1'b0, 1'b1);

        // Freeze at Duty=50 during RISE; the next step must shift by the pause
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step_cycle();
            if (bus_a.Duty == 50) found = 1'b1;
        end
        chk("reach_50", found, 1);
        drive(1'b0, 1'b0);
        repeat (20) step_cycle();
        chk("freeze_duty", bus_a.Duty, 50);
        chk("freeze_tick", bus_a.Period_Tick, 0);
        drive(1'b0, 1'b1);
        repeat (7) step_cycle();
        chk("resume_pre",  bus_a.Duty, 50);
        step_cycle();
        chk("resume_step", bus_a.Duty, 75);

        // Random Enable gaps with rare resets
        repeat (1500) begin
            drive($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0);
            step_cycle();
        end

        chk("end_countp_b", bus_b.Count_P, P);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/breathing_duty_sequencer.md
# breathing_duty_sequencer

Generates a slowly ramping duty-cycle value (0–100 %) and a fixed PWM period count for the PWM generator stage, producing a "breathing" LED effect. Sits directly upstream of the PWM generator: its Duty and Count_P outputs drive that stage's inputs. Duty changes only on PWM period boundaries, so each PWM period uses one stable duty value.

## Interface
- PERIOD_CYCLES, 50000: PWM period in CLK cycles (1 kHz at 50 MHz); legal range 2..167772 (PERIOD_CYCLES*100 < 2^24).
- STEP_PERIODS, 10: PWM periods between duty steps; ≥1.
- DUTY_STEP, 1: duty increment/decrement per step, percent; 1..100.
- DUTY_MAX, 100: ramp ceiling, percent; ≤100.
- HOLD_PERIODS, 50: PWM periods spent at each extreme (hold build only); ≥1.
- CLK  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Enable  in  1  1 = run; 0 = freeze all counters and outputs.
- Duty  out  8  current duty, percent, 0..DUTY_MAX.
- Count_P  out  24  PWM period in cycles; constant PERIOD_CYCLES.
- Period_Tick  out  1  one-cycle strobe in the last cycle of each PWM period.
- Phase  out  2  FSM state: 0 RISE, 1 HOLD_HI, 2 FALL, 3 HOLD_LO.

## Operation
- Reset values: Duty=0, Phase=RISE, Period_Tick=0, Count_P=PERIOD_CYCLES; period, step and hold counters = 0.
- Period counter: 0..PERIOD_CYCLES-1, wraps to 0; Period_Tick=1 when counter==PERIOD_CYCLES-1 and Enable=1.
- Step counter: counts Period_Ticks in RISE/FALL; the STEP_PERIODS-th tick is a step event and clears the counter.
- RISE, step event: Duty ← min(Duty+DUTY_STEP, DUTY_MAX). If the result equals DUTY_MAX → HOLD_HI.
- HOLD_HI: hold counter counts ticks; on the HOLD_PERIODS-th tick → FALL. Duty unchanged.
- FALL, step event: Duty ← max(Duty−DUTY_STEP, 0), computed without 8-bit underflow. If the result is 0 → HOLD_LO.
- HOLD_LO: same as HOLD_HI, then → RISE.
- Step and hold counters clear on every state transition.
- Enable=0: no counter advances, Period_Tick=0, Duty and Phase hold. Resuming continues from the frozen counts.
- Rst has priority over Enable. A reset mid-ramp returns all outputs to their reset values on the next edge.

## Timing
- Duty, Phase and Period_Tick are registered; Count_P is a constant.
- A step event occurs in a Period_Tick cycle. The new Duty is visible from the next edge, which is the first cycle of the next period (counter=0).
- Saturation and the state transition happen on the same edge as the final step.
- Step latency: first Duty change after reset at cycle STEP_PERIODS*PERIOD_CYCLES.

## Configuration
- BREATH_HOLD_EN defined: HOLD_HI and HOLD_LO states are present, as described above.
- BREATH_HOLD_EN undefined:
  - Reaching DUTY_MAX goes straight RISE→FALL; reaching 0 goes straight FALL→RISE.
  - Phase only ever shows 0 or 2.
  - HOLD_PERIODS is ignored and the hold counter is not built.

## Structure
- Shared package breathing_pkg holds:
  - the phase enum (RISE/HOLD_HI/FALL/HOLD_LO, 2-bit);
  - the DUTY_W=8 and COUNT_W=24 width constants;
  - the DUTY_ABS_MAX=100 constant.
- One sub-module, period_tick_gen: period counter plus Period_Tick, parameterised by PERIOD_CYCLES, with an Enable input.
- The FSM and the step/hold counters live in the top module.

## Test plan
All scenarios use PERIOD_CYCLES=4, STEP_PERIODS=2, DUTY_STEP=25, DUTY_MAX=100, HOLD_PERIODS=3 unless stated.
- Reset: Rst=1 for 2 cycles → Duty=0, Phase=0, Period_Tick=0, Count_P=4.
- Ramp up: Enable=1 after reset → Period_Tick at cycles 3, 7, 11…; Duty=25/50/75/100 from cycles 8/16/24/32; Phase=1 from cycle 32.
- Hold and fall (BREATH_HOLD_EN): Duty stays 100 for 3 ticks, then Phase=2; Duty=75 appears one step period later; the ramp ends at Duty=0 with Phase=3.
- Saturation: DUTY_STEP=30 → Duty sequence 0, 30, 60, 90, 100. The fall from 100 gives 70, 40, 10, 0 with no wrap.
- Freeze: Enable=0 for 20 cycles mid-RISE at Duty=50 → Duty=50 and no Period_Tick. After Enable=1 the next step lands exactly where it would have without the pause (pause length offset).
- No-hold build (BREATH_HOLD_EN undefined): the edge after Duty reaches 100 shows Phase=2; Phase never equals 1 or 3 over 2 full cycles. A Rst pulse mid-FALL gives Duty=0, Phase=0 on the next edge.
